irq_controller: RTL
===================

// Module: irq_controller
// PURPOSE
//  Parametrised interrupt controller: latches edges from NUM_SRC sources (LCD copy/render done,
//  timers, 32/8/2/1 Hz ticks, ...), holds per-source enable and priority in memory-mapped
//  registers, and presents the highest-priority pending request (vector + level) to the CPU.
//  Sits on the system bus beside the timer/LCD blocks and drives the CPU interrupt inputs.
// PARAMETERS
//  NUM_SRC    32        number of sources; multiple of 8, max 64
//  PRIO_BITS  2         priority width per source; 0 = masked, higher wins
//  BASE_ADDR  24'h2020  first register byte
//  VEC_BASE   8'h03     vector of source 0; source i -> VEC_BASE+i
// PORTS
//  clk             in   1          clock
//  reset           in   1          synchronous, active-high
//  bus_write       in   1          1-cycle write strobe
//  bus_read        in   1          read strobe (no side effects)
//  bus_address_in  in   24         byte address
//  bus_data_in     in   8          write data
//  bus_data_out    out  8          read data, combinational; 0 outside map
//  irq_src         in   NUM_SRC    level inputs, rising edge = event
//  cpu_irq_mask    in   PRIO_BITS  CPU current level; only strictly higher priorities request
//  irq_req         out  1          registered request
//  irq_vector      out  8          registered vector of presented source
//  irq_prio        out  PRIO_BITS  registered priority of presented source
//  irq_ack         in   1          1-cycle CPU acknowledge of presented vector
// BEHAVIOUR
//  Reset: flags, enables, priorities, irq_req, irq_vector, irq_prio all 0; edge-detect history
//   loads irq_src so a source held high across reset raises no flag.
//  Map (bytes from BASE_ADDR): [0, NUM_SRC/4) priority, 4 sources/byte, source 4k in bits[1:0]
//   (PRIO_BITS=2 packing); next NUM_SRC/8 enable, 1 bit/source; next NUM_SRC/8 flags.
//  Writes commit on the posedge with bus_write high. Priority/enable bytes: plain store.
//   Flag bytes: write-1-to-clear; 0 bits have no effect.
//  Edge detect: flag[i] sets on the cycle after irq_src[i] is sampled 0 then 1, whether or not
//   the source is enabled (software polls flags).
//  Eligible: flag & enable & prio > cpu_irq_mask. Selection: highest prio; ties -> lowest index.
//  Outputs registered every cycle from the eligible set: irq_req=|eligible. Latency: src rises
//   in sample cycle N -> flag at N+1 -> irq_req/vector at N+2. Vector/prio hold last
//   value when irq_req=0.
//  Clearing or masking the presented source drops/re-arbitrates irq_req the next cycle.
//  Simultaneous set (edge) and clear (W1C or auto-clear) on one bit: set wins.
//  irq_ack while irq_req=0: ignored. Reset mid-request: irq_req drops the next cycle.
// CONFIGURATION
//  IRQ_AUTO_CLEAR_EN defined: irq_ack clears the flag of the source in irq_vector; irq_req
//   is forced 0 in the cycle after ack (no stale re-present), then re-arbitrates.
//  Not defined: irq_ack ignored; flags clear only by software W1C.
// STRUCTURE
//  irq_pkg: register-block offsets (PRIO/ENABLE/FLAG), NUM_SRC limits, prio_t typedef,
//   function addr->(block, byte index).
//  Sub-module irq_prio_encoder: combinational tree over eligible/prio vectors, returns
//   valid, index and prio; instantiated once.
// TESTING
//  1 reset with irq_src[5]=1 held, then enable 5, prio 2 -> flag5 stays 0, irq_req=0.
//  2 enable 0 (prio 1) and 3 (prio 3); pulse both same cycle; mask 0 -> irq_req at +2 cycles,
//    vector 8'h06, prio 3; W1C bit3 -> next cycle vector 8'h03, prio 1.
//  3 sources 2 and 9 both prio 2 pending -> vector 8'h05 (lowest index wins).
//  4 cpu_irq_mask=2 with only prio-2 pending -> irq_req=0; mask=1 -> irq_req=1 after 1 clk.
//  5 edge on src 4 same cycle as W1C of flag4 -> flag4 reads 1.
//  6 IRQ_AUTO_CLEAR_EN: ack vector 8'h07 -> flag4 0, irq_req 0 next cycle; without macro,
//    flag4 stays 1 and irq_req stays 1.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register-block selection,
// source-count limits, priority type and the bus address decoder.
// No ports; imported by irq_controller.
package irq_pkg;

    localparam int NUM_SRC_MAX   = 64;
    localparam int NUM_SRC_MULT  = 8;
    localparam int PRIO_BITS_DEF = 2;

    typedef logic [PRIO_BITS_DEF-1:0] prio_t;

    // Register blocks in address order: priority bytes, enable bytes, flag bytes.
    typedef enum logic [1:0] {
        BLK_NONE   = 2'd0,
        BLK_PRIO   = 2'd1,
        BLK_ENABLE = 2'd2,
        BLK_FLAG   = 2'd3
    } blk_e;

    typedef struct packed {
        blk_e       blk;
        logic [7:0] idx;   // byte index inside the selected block
    } reg_sel_t;

    // Maps a bus byte address to (block, byte index). Addresses below the base
    // wrap to a huge offset in the subtraction and so fall outside the map.
    function automatic reg_sel_t decode_addr(
        input logic [23:0] addr,
        input logic [23:0] base,
        input int          num_src,
        input int          prio_bits
    );
        logic [23:0] off;
        logic [23:0] en_off;
        logic [23:0] flag_off;
        logic [23:0] map_end;
        reg_sel_t    sel;
        off      = addr - base;
        en_off   = 24'(num_src * prio_bits / 8);
        flag_off = en_off + 24'(num_src / 8);
        map_end  = flag_off + 24'(num_src / 8);
        sel.blk  = BLK_NONE;
        sel.idx  = 8'd0;
        if (off < en_off) begin
            sel.blk = BLK_PRIO;
            sel.idx = 8'(off);
        end else if (off < flag_off) begin
            sel.blk = BLK_ENABLE;
            sel.idx = 8'(off - en_off);
        end else if (off < map_end) begin
            sel.blk = BLK_FLAG;
            sel.idx = 8'(off - flag_off);
        end
        return sel;
    endfunction

endpackage

// File: rtl/irq_prio_encoder.sv
// Combinational priority selector: binary tree over the eligible sources,
// picking the highest priority, ties going to the lower index.
// Ports: eligible/prio_flat in; vld, idx, prio of the winner out.
module irq_prio_encoder #(
    parameter int N         = 32,
    parameter int PRIO_BITS = 2
) (
    input  logic [N-1:0]           eligible,
    input  logic [N*PRIO_BITS-1:0] prio_flat,
    output logic                   vld,
    output logic [$clog2(N)-1:0]   idx,
    output logic [PRIO_BITS-1:0]   prio
);

    localparam int LEVELS = $clog2(N);
    localparam int NP     = 1 << LEVELS;

    logic                 t_vld  [LEVELS+1][NP];
    logic [PRIO_BITS-1:0] t_prio [LEVELS+1][NP];
    logic [LEVELS-1:0]    t_idx  [LEVELS+1][NP];

    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            for (int j = 0; j < NP; j++) begin
                t_vld[l][j]  = 1'b0;
                t_prio[l][j] = '0;
                t_idx[l][j]  = '0;
            end
        end
        for (int j = 0; j < N; j++) begin
            t_vld[0][j]  = eligible[j];
            t_prio[0][j] = prio_flat[j*PRIO_BITS +: PRIO_BITS];
            t_idx[0][j]  = LEVELS'(j);
        end
        // The right (higher-index) child wins only on a strictly higher priority.
        for (int l = 0; l < LEVELS; l++) begin
            for (int j = 0; j < (NP >> (l + 1)); j++) begin
                if (t_vld[l][2*j+1] &&
                    (!t_vld[l][2*j] || (t_prio[l][2*j+1] > t_prio[l][2*j]))) begin
                    t_vld[l+1][j]  = 1'b1;
                    t_prio[l+1][j] = t_prio[l][2*j+1];
                    t_idx[l+1][j]  = t_idx[l][2*j+1];
                end else begin
                    t_vld[l+1][j]  = t_vld[l][2*j];
                    t_prio[l+1][j] = t_prio[l][2*j];
                    t_idx[l+1][j]  = t_idx[l][2*j];
                end
            end
        end
        vld  = t_vld[LEVELS][0];
        idx  = t_idx[LEVELS][0];
        prio = t_prio[LEVELS][0];
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-latched flags, per-source enable/priority registers,
// registered highest-priority request (vector + level) to the CPU.
// Ports: clk/reset (sync, active-high); byte bus (bus_write/bus_read/bus_address_in/
// bus_data_in/bus_data_out); irq_src in; cpu_irq_mask in; irq_req/irq_vector/irq_prio out;
// irq_ack in. Optional IRQ_AUTO_CLEAR_EN: acknowledge clears the presented flag.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_SRC   = 32,
    parameter int          PRIO_BITS = 2,
    parameter logic [23:0] BASE_ADDR = 24'h2020,
    parameter logic [7:0]  VEC_BASE  = 8'h03
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bus_write,
    input  logic                 bus_read,
    input  logic [23:0]          bus_address_in,
    input  logic [7:0]           bus_data_in,
    output logic [7:0]           bus_data_out,
    input  logic [NUM_SRC-1:0]   irq_src,
    input  logic [PRIO_BITS-1:0] cpu_irq_mask,
    output logic                 irq_req,
    output logic [7:0]           irq_vector,
    output logic [PRIO_BITS-1:0] irq_prio,
    input  logic                 irq_ack
);

    localparam int PRIO_BYTES = NUM_SRC * PRIO_BITS / 8;
    localparam int BIT_BYTES  = NUM_SRC / 8;
    localparam int IDX_W      = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]           src_hist;
    logic [NUM_SRC-1:0]           flag;
    logic [NUM_SRC-1:0]           enable;
    logic [NUM_SRC*PRIO_BITS-1:0] prio_flat;
    logic [NUM_SRC-1:0]           edge_set;
    logic [NUM_SRC-1:0]           w1c_clr;
    logic [NUM_SRC-1:0]           ack_clr;
    logic [NUM_SRC-1:0]           eligible;
    logic                         ack_take;
    reg_sel_t                     sel;
    logic                         enc_vld;
    logic [IDX_W-1:0]             enc_idx;
    logic [PRIO_BITS-1:0]         enc_prio;

    // Reads have no side effects, so the strobe carries no information here.
    logic unused_ok;
    assign unused_ok = ^{bus_read, irq_ack};

    assign sel      = decode_addr(bus_address_in, BASE_ADDR, NUM_SRC, PRIO_BITS);
    assign edge_set = irq_src & ~src_hist;

    always_comb begin
        w1c_clr = '0;
        if (bus_write && sel.blk == BLK_FLAG) begin
            for (int b = 0; b < BIT_BYTES; b++) begin
                if (sel.idx == 8'(b)) begin
                    w1c_clr[b*8 +: 8] = bus_data_in;
                end
            end
        end
    end

`ifdef IRQ_AUTO_CLEAR_EN
    // Index of the source currently shown in irq_vector, kept to avoid subtracting VEC_BASE.
    logic [IDX_W-1:0] cur_idx;

    assign ack_take = irq_ack & irq_req;

    always_comb begin
        ack_clr = '0;
        if (ack_take) begin
            ack_clr[cur_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_idx <= '0;
        end else if (enc_vld && !ack_take) begin
            cur_idx <= enc_idx;
        end
    end
`else
    assign ack_take = 1'b0;
    assign ack_clr  = '0;
`endif

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = flag[i] & enable[i] &
                          (prio_flat[i*PRIO_BITS +: PRIO_BITS] > cpu_irq_mask);
        end
    end

    irq_prio_encoder #(
        .N         (NUM_SRC),
        .PRIO_BITS (PRIO_BITS)
    ) u_prio_encoder (
        .eligible  (eligible),
        .prio_flat (prio_flat),
        .vld       (enc_vld),
        .idx       (enc_idx),
        .prio      (enc_prio)
    );

    // History loads the live inputs in reset so a source held high raises no flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_hist  <= irq_src;
            flag      <= '0;
            enable    <= '0;
            prio_flat <= '0;
        end else begin
            src_hist <= irq_src;
            // OR-ing the edge in last makes a simultaneous set beat any clear.
            flag     <= (flag & ~(w1c_clr | ack_clr)) | edge_set;
            if (bus_write) begin
                for (int b = 0; b < PRIO_BYTES; b++) begin
                    if (sel.blk == BLK_PRIO && sel.idx == 8'(b)) begin
                        prio_flat[b*8 +: 8] <= bus_data_in;
                    end
                end
                for (int b = 0; b < BIT_BYTES; b++) begin
                    if (sel.blk == BLK_ENABLE && sel.idx == 8'(b)) begin
                        enable[b*8 +: 8] <= bus_data_in;
                    end
                end
            end
        end
    end

    // The encoder sees the flags before the ack clear lands, so the cycle after
    // an accepted ack is forced idle; vector/prio keep their last value when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_req    <= 1'b0;
            irq_vector <= 8'h00;
            irq_prio   <= '0;
        end else if (ack_take) begin
            irq_req <= 1'b0;
        end else begin
            irq_req <= enc_vld;
            if (enc_vld) begin
                irq_vector <= VEC_BASE + 8'(enc_idx);
                irq_prio   <= enc_prio;
            end
        end
    end

    always_comb begin
        bus_data_out = 8'h00;
        for (int b = 0; b < PRIO_BYTES; b++) begin
            if (sel.blk == BLK_PRIO && sel.idx == 8'(b)) begin
                bus_data_out = prio_flat[b*8 +: 8];
            end
        end
        for (int b = 0; b < BIT_BYTES; b++) begin
            if (sel.blk == BLK_ENABLE && sel.idx == 8'(b)) begin
                bus_data_out = enable[b*8 +: 8];
            end
            if (sel.blk == BLK_FLAG && sel.idx == 8'(b)) begin
                bus_data_out = flag[b*8 +: 8];
            end
        end
    end

endmodule
